// File: rtl/rob.sv
// -----------------------------------------------------------------------------
// rob: reorder buffer for the out-of-order core.
//
// Entries are allocated in program order at the tail. Results arrive out of
// order on the writeback bus, and the head entry retires once its result is in.
// Retiring a taken branch or an excepting instruction flushes the whole buffer
// on the following clock edge.
//
// Handshake: a dispatch is transferred on a clock edge where
// disp_valid && disp_ready. disp_valid may be held across cycles. disp_ready
// does not depend on disp_valid.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   disp_valid/dst_addr/dst_wen    dispatch request from decode
//   disp_ready                     an entry can be taken this cycle
//   allocate_en, rob_alloc_*_2rat  allocation (tag, dst, wen) to the alias table
//   wb_en/tag/data/br_taken/
//     br_target/exp                writeback bus
//   rd1_tag/rd2_tag                operand lookup tags from issue
//   rd1_done/data, rd2_done/data   operand result (with same-cycle wb bypass)
//   commit_en, rob_commit_*        retirement of the head entry
// -----------------------------------------------------------------------------
module rob #(
    parameter int ROB_DEPTH      = 8,
    parameter int GPR_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = 32,
    localparam int TAG_W         = $clog2(ROB_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      disp_valid,
    input  logic [GPR_ADDR_WIDTH-1:0] disp_dst_addr,
    input  logic                      disp_dst_wen,
    output logic                      disp_ready,

    output logic                      allocate_en,
    output logic [TAG_W-1:0]          rob_alloc_tag_2rat,
    output logic [GPR_ADDR_WIDTH-1:0] rob_alloc_dst_addr_2rat,
    output logic                      rob_alloc_dst_wen_2rat,

    input  logic                      wb_en,
    input  logic [TAG_W-1:0]          wb_tag,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    input  logic                      wb_br_taken,
    input  logic [DATA_WIDTH-1:0]     wb_br_target,
    input  logic                      wb_exp,

    input  logic [TAG_W-1:0]          rd1_tag,
    input  logic [TAG_W-1:0]          rd2_tag,
    output logic                      rd1_done,
    output logic                      rd2_done,
    output logic [DATA_WIDTH-1:0]     rd1_data,
    output logic [DATA_WIDTH-1:0]     rd2_data,

    output logic                      commit_en,
    output logic [GPR_ADDR_WIDTH-1:0] rob_commit_dst_addr_2rat,
    output logic                      rob_commit_wen,
    output logic [DATA_WIDTH-1:0]     rob_commit_data,
    output logic                      rob_commit_br_taken,
    output logic                      rob_commit_exp_en,
    output logic [DATA_WIDTH-1:0]     rob_commit_redirect_pc
);

    localparam logic [TAG_W:0]   FULL_COUNT = (TAG_W+1)'(ROB_DEPTH);
    localparam logic [TAG_W:0]   CNT_ONE    = (TAG_W+1)'(1);
    localparam logic [TAG_W-1:0] TAG_ONE    = TAG_W'(1);

    // Per-entry state
    logic [ROB_DEPTH-1:0]      valid_q;
    logic [ROB_DEPTH-1:0]      done_q;
    logic [ROB_DEPTH-1:0]      wen_q;
    logic [ROB_DEPTH-1:0]      br_q;
    logic [ROB_DEPTH-1:0]      exc_q;
    logic [GPR_ADDR_WIDTH-1:0] dst_q    [ROB_DEPTH];
    logic [DATA_WIDTH-1:0]     data_q   [ROB_DEPTH];
    logic [DATA_WIDTH-1:0]     target_q [ROB_DEPTH];

    // Pointers
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;

    logic full;
    logic empty;
    logic flush;
    logic wb_accept;
    logic rd1_bypass;
    logic rd2_bypass;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);

    // Commit is purely combinational from the head entry.
    assign commit_en           = !empty && valid_q[head_q] && done_q[head_q];
    assign rob_commit_br_taken = commit_en && br_q[head_q];
    assign rob_commit_exp_en   = commit_en && exc_q[head_q];
    assign flush               = rob_commit_br_taken || rob_commit_exp_en;

    assign rob_commit_wen           = commit_en && wen_q[head_q] && !exc_q[head_q];
    assign rob_commit_dst_addr_2rat = (commit_en && wen_q[head_q]) ? dst_q[head_q] : '0;
    assign rob_commit_data          = commit_en ? data_q[head_q] : '0;
    assign rob_commit_redirect_pc   = rob_commit_br_taken ? target_q[head_q] : '0;

    // A committing flush blocks dispatch so the first post-flush tag is 0.
    assign disp_ready              = !full && !flush;
    assign allocate_en             = disp_valid && disp_ready;
    assign rob_alloc_tag_2rat      = tail_q;
    assign rob_alloc_dst_addr_2rat = disp_dst_addr;
    assign rob_alloc_dst_wen_2rat  = disp_dst_wen;

    assign wb_accept = wb_en && valid_q[wb_tag];

    // Operand read with same-cycle bypass from the writeback bus.
    assign rd1_bypass = wb_en && (wb_tag == rd1_tag) && valid_q[rd1_tag];
    assign rd2_bypass = wb_en && (wb_tag == rd2_tag) && valid_q[rd2_tag];
    assign rd1_done   = (valid_q[rd1_tag] && done_q[rd1_tag]) || rd1_bypass;
    assign rd2_done   = (valid_q[rd2_tag] && done_q[rd2_tag]) || rd2_bypass;
    assign rd1_data   = rd1_bypass ? wb_data : data_q[rd1_tag];
    assign rd2_data   = rd2_bypass ? wb_data : data_q[rd2_tag];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (commit_en)   head_d = head_q + TAG_ONE;
            if (allocate_en) tail_d = tail_q + TAG_ONE;
            if (allocate_en && !commit_en)      count_d = count_q + CNT_ONE;
            else if (commit_en && !allocate_en) count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
            wen_q   <= '0;
            br_q    <= '0;
            exc_q   <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                dst_q[i]    <= '0;
                data_q[i]   <= '0;
                target_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (flush) begin
                // Whole buffer is discarded; a same-cycle writeback is dropped.
                valid_q <= '0;
                done_q  <= '0;
            end else begin
                // The tail entry is never valid when allocating, so allocation
                // and writeback never target the same entry.
                if (allocate_en) begin
                    valid_q[tail_q]  <= 1'b1;
                    done_q[tail_q]   <= 1'b0;
                    br_q[tail_q]     <= 1'b0;
                    exc_q[tail_q]    <= 1'b0;
                    data_q[tail_q]   <= '0;
                    dst_q[tail_q]    <= disp_dst_addr;
                    wen_q[tail_q]    <= disp_dst_wen;
                end
                if (wb_accept) begin
                    done_q[wb_tag]   <= 1'b1;
                    data_q[wb_tag]   <= wb_data;
                    br_q[wb_tag]     <= wb_br_taken;
                    target_q[wb_tag] <= wb_br_target;
                    exc_q[wb_tag]    <= wb_exp;
                end
                if (commit_en) begin
                    valid_q[head_q]  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rob.sv
module tb_rob;

  localparam int DEPTH = 8;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int TW    = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          disp_valid;
  logic [AW-1:0] disp_dst_addr;
  logic          disp_dst_wen;
  logic          disp_ready;
  logic          allocate_en;
  logic [TW-1:0] rob_alloc_tag_2rat;
  logic [AW-1:0] rob_alloc_dst_addr_2rat;
  logic          rob_alloc_dst_wen_2rat;
  logic          wb_en;
  logic [TW-1:0] wb_tag;
  logic [DW-1:0] wb_data;
  logic          wb_br_taken;
  logic [DW-1:0] wb_br_target;
  logic          wb_exp;
  logic [TW-1:0] rd1_tag, rd2_tag;
  logic          rd1_done, rd2_done;
  logic [DW-1:0] rd1_data, rd2_data;
  logic          commit_en;
  logic [AW-1:0] rob_commit_dst_addr_2rat;
  logic          rob_commit_wen;
  logic [DW-1:0] rob_commit_data;
  logic          rob_commit_br_taken;
  logic          rob_commit_exp_en;
  logic [DW-1:0] rob_commit_redirect_pc;

  rob #(.ROB_DEPTH(DEPTH), .GPR_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_dst_addr(disp_dst_addr), .disp_dst_wen(disp_dst_wen),
    .disp_ready(disp_ready),
    .allocate_en(allocate_en), .rob_alloc_tag_2rat(rob_alloc_tag_2rat),
    .rob_alloc_dst_addr_2rat(rob_alloc_dst_addr_2rat), .rob_alloc_dst_wen_2rat(rob_alloc_dst_wen_2rat),
    .wb_en(wb_en), .wb_tag(wb_tag), .wb_data(wb_data), .wb_br_taken(wb_br_taken),
    .wb_br_target(wb_br_target), .wb_exp(wb_exp),
    .rd1_tag(rd1_tag), .rd2_tag(rd2_tag), .rd1_done(rd1_done), .rd2_done(rd2_done),
    .rd1_data(rd1_data), .rd2_data(rd2_data),
    .commit_en(commit_en), .rob_commit_dst_addr_2rat(rob_commit_dst_addr_2rat),
    .rob_commit_wen(rob_commit_wen), .rob_commit_data(rob_commit_data),
    .rob_commit_br_taken(rob_commit_br_taken), .rob_commit_exp_en(rob_commit_exp_en),
    .rob_commit_redirect_pc(rob_commit_redirect_pc)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [AW-1:0] exp_q[$];   // hand-written expected commit destinations

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Live instructions in program order; position 0 is the oldest.
  typedef struct {
    int            tag;
    logic [AW-1:0] dst;
    logic          wen;
    logic          done;
    logic [DW-1:0] data;
    logic          br;
    logic [DW-1:0] tgt;
    logic          ex;
  } ent_t;

  ent_t mq[$];
  int   next_tag = 0;

  function automatic int find_tag(input int tag);
    foreach (mq[i]) if (mq[i].tag == tag) return i;
    return -1;
  endfunction

  function automatic logic m_commit();
    return (mq.size() > 0) && mq[0].done;
  endfunction

  function automatic logic m_flush();
    return m_commit() && (mq[0].br || mq[0].ex);
  endfunction

  function automatic logic m_ready();
    return (mq.size() < DEPTH) && !m_flush();
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      next_tag = 0;
    end else if (m_flush()) begin
      mq.delete();
      next_tag = 0;
    end else begin
      logic c;
      logic acc;
      int   k;
      ent_t e;
      c   = m_commit();
      acc = disp_valid && m_ready();
      if (wb_en) begin
        k = find_tag(int'(wb_tag));
        if (k >= 0) begin
          mq[k].done = 1'b1;
          mq[k].data = wb_data;
          mq[k].br   = wb_br_taken;
          mq[k].tgt  = wb_br_target;
          mq[k].ex   = wb_exp;
        end
      end
      if (c) void'(mq.pop_front());
      if (acc) begin
        e.tag = next_tag; e.dst = disp_dst_addr; e.wen = disp_dst_wen;
        e.done = 1'b0; e.data = '0; e.br = 1'b0; e.tgt = '0; e.ex = 1'b0;
        mq.push_back(e);
        next_tag = (next_tag + 1) % DEPTH;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic c, rdy, d1, d2, b1, b2;
    int   i1, i2;
    c   = m_commit();
    rdy = m_ready();
    chk("disp_ready", disp_ready, rdy);
    chk("allocate_en", allocate_en, disp_valid && rdy);
    if (disp_valid && rdy) chk("alloc_tag", rob_alloc_tag_2rat, next_tag);
    chk("alloc_dst", rob_alloc_dst_addr_2rat, disp_dst_addr);
    chk("alloc_wen", rob_alloc_dst_wen_2rat, disp_dst_wen);
    chk("commit_en", commit_en, c);
    chk("commit_br", rob_commit_br_taken, c && mq[0].br);
    chk("commit_exp", rob_commit_exp_en, c && mq[0].ex);
    chk("commit_wen", rob_commit_wen, c && mq[0].wen && !mq[0].ex);
    chk("commit_dst", rob_commit_dst_addr_2rat, (c && mq[0].wen) ? mq[0].dst : '0);
    chk("redirect_pc", rob_commit_redirect_pc, (c && mq[0].br) ? mq[0].tgt : '0);
    if (c) chk("commit_data", rob_commit_data, mq[0].data);
    if (commit_en && exp_q.size() > 0) chk("commit_order", rob_commit_dst_addr_2rat, exp_q.pop_front());
    i1 = find_tag(int'(rd1_tag));
    i2 = find_tag(int'(rd2_tag));
    b1 = wb_en && (wb_tag == rd1_tag) && (i1 >= 0);
    b2 = wb_en && (wb_tag == rd2_tag) && (i2 >= 0);
    d1 = ((i1 >= 0) && mq[i1].done) || b1;
    d2 = ((i2 >= 0) && mq[i2].done) || b2;
    chk("rd1_done", rd1_done, d1);
    chk("rd2_done", rd2_done, d2);
    if (d1) chk("rd1_data", rd1_data, b1 ? wb_data : mq[i1].data);
    if (d2) chk("rd2_data", rd2_data, b2 ? wb_data : mq[i2].data);
  end

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    disp_valid = 1'b0; disp_dst_addr = '0; disp_dst_wen = 1'b0;
    wb_en = 1'b0; wb_tag = '0; wb_data = '0; wb_br_taken = 1'b0; wb_br_target = '0; wb_exp = 1'b0;
    rd1_tag = '0; rd2_tag = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input int dst, input logic wen);
    disp_valid = 1'b1; disp_dst_addr = AW'(dst); disp_dst_wen = wen;
  endtask

  task automatic wb(input int tag, input int data, input logic br, input int tgt, input logic ex);
    wb_en = 1'b1; wb_tag = TW'(tag); wb_data = DW'(data);
    wb_br_taken = br; wb_br_target = DW'(tgt); wb_exp = ex;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    set_idle();
    tick();
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      dispatch(i + 1, 1'b1);
      #2;
      chk("fill_tag", rob_alloc_tag_2rat, i);
      tick();
    end
    disp_valid = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    set_idle();
    #3;
    chk("rst_ready", disp_ready, 1);
    chk("rst_alloc", allocate_en, 0);
    chk("rst_commit", commit_en, 0);
    chk("rst_rd1", rd1_done, 0);
    chk("rst_cdata", rob_commit_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // In-order commit of out-of-order completions
    dispatch(5, 1'b1); #2; chk("t1_tag0", rob_alloc_tag_2rat, 0); tick();
    dispatch(6, 1'b1); #2; chk("t1_tag1", rob_alloc_tag_2rat, 1); tick();
    dispatch(0, 1'b0); #2; chk("t1_tag2", rob_alloc_tag_2rat, 2); tick();
    set_idle();
    exp_q.push_back(5); exp_q.push_back(6); exp_q.push_back(0);
    wb(1, 'h11, 0, 0, 0); tick();
    wb(0, 'h10, 0, 0, 0); #2; chk("t1_no_early", commit_en, 0); tick();
    wb(2, 'h12, 0, 0, 0); #2;
    chk("t1_c0_en", commit_en, 1); chk("t1_c0_dst", rob_commit_dst_addr_2rat, 5);
    chk("t1_c0_data", rob_commit_data, 'h10); chk("t1_c0_wen", rob_commit_wen, 1);
    tick();
    set_idle(); #2; chk("t1_c1_dst", rob_commit_dst_addr_2rat, 6); chk("t1_c1_data", rob_commit_data, 'h11);
    tick();
    #2; chk("t1_c2_en", commit_en, 1); chk("t1_c2_wen", rob_commit_wen, 0); chk("t1_c2_dst", rob_commit_dst_addr_2rat, 0);
    tick();
    #2; chk("t1_drained", exp_q.size(), 0); chk("t1_idle", commit_en, 0);
    tick();

    // Full buffer, commit and dispatch in the same cycle, wrap
    pulse_reset();
    fill(8);
    dispatch(9, 1'b1);
    #2; chk("t2_full_ready", disp_ready, 0); chk("t2_full_alloc", allocate_en, 0);
    wb(0, 'h90, 0, 0, 0); tick();
    wb_en = 1'b0;
    #2; chk("t2_commit", commit_en, 1); chk("t2_refused", disp_ready, 0); chk("t2_no_alloc", allocate_en, 0);
    tick();
    #2; chk("t2_space", disp_ready, 1); chk("t2_wrap_tag", rob_alloc_tag_2rat, 0);
    tick();
    set_idle(); tick();

    // Taken branch flushes the buffer
    pulse_reset();
    fill(4);
    wb(1, 'h21, 1, 'h100, 0); tick();
    wb(0, 'h20, 0, 0, 0); #2; chk("t3_wait", commit_en, 0); tick();
    wb_en = 1'b0;
    #2; chk("t3_c0", commit_en, 1); chk("t3_c0_br", rob_commit_br_taken, 0);
    chk("t3_c0_pc", rob_commit_redirect_pc, 0); chk("t3_c0_ready", disp_ready, 1);
    tick();
    dispatch(3, 1'b1);
    #2; chk("t3_c1", commit_en, 1); chk("t3_c1_br", rob_commit_br_taken, 1);
    chk("t3_c1_pc", rob_commit_redirect_pc, 'h100); chk("t3_flush_ready", disp_ready, 0);
    chk("t3_flush_alloc", allocate_en, 0);
    tick();
    #2; chk("t3_after_commit", commit_en, 0); chk("t3_after_ready", disp_ready, 1);
    chk("t3_after_tag", rob_alloc_tag_2rat, 0);
    tick();
    set_idle(); tick();

    // Exception at the head
    pulse_reset();
    dispatch(7, 1'b1); #2; chk("t4_tag", rob_alloc_tag_2rat, 0); tick();
    set_idle();
    wb(0, 'hDEAD, 0, 0, 1); tick();
    wb_en = 1'b0;
    #2; chk("t4_commit", commit_en, 1); chk("t4_exp", rob_commit_exp_en, 1);
    chk("t4_wen", rob_commit_wen, 0); chk("t4_ready", disp_ready, 0); chk("t4_br", rob_commit_br_taken, 0);
    tick();
    #2; chk("t4_empty", commit_en, 0); chk("t4_ready_back", disp_ready, 1);
    tick();

    // Operand bypass and invalid tag
    pulse_reset();
    fill(4);
    rd1_tag = 3; rd2_tag = 4;
    wb(3, 'h55, 0, 0, 0);
    #2; chk("t5_byp_done", rd1_done, 1); chk("t5_byp_data", rd1_data, 'h55); chk("t5_inv_done", rd2_done, 0);
    tick();
    wb_en = 1'b0; rd2_tag = 2;
    #2; chk("t5_reg_done", rd1_done, 1); chk("t5_reg_data", rd1_data, 'h55); chk("t5_pend", rd2_done, 0);
    tick();

    // Asynchronous reset mid-operation
    pulse_reset();
    fill(5);
    wb(0, 'h77, 0, 0, 0); rd1_tag = 0; tick();
    wb_en = 1'b0;
    #2; chk("t6_pre_commit", commit_en, 1); chk("t6_pre_rd", rd1_done, 1);
    rst = 1'b1;
    #1; chk("t6_rst_ready", disp_ready, 1); chk("t6_rst_commit", commit_en, 0); chk("t6_rst_rd", rd1_done, 0);
    rst = 1'b0;
    set_idle(); tick();
    dispatch(12, 1'b1); #2; chk("t6_first_tag", rob_alloc_tag_2rat, 0); tick();
    set_idle(); tick();

    // Steady stream across several wraps, checked by the model
    pulse_reset();
    for (int k = 0; k < 24; k++) begin
      dispatch(k % 32, (k % 3) != 0);
      if (k >= 2) wb((k - 2) % DEPTH, k * 3, 0, 0, 0);
      else wb_en = 1'b0;
      tick();
    end
    disp_valid = 1'b0;
    wb(22 % DEPTH, 66, 0, 0, 0); tick();
    wb(23 % DEPTH, 69, 0, 0, 0); tick();
    set_idle();
    for (int k = 0; k < 4; k++) tick();
    #2; chk("t7_drained", commit_en, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
